// File: rtl/int_stb_gen.sv
// int_stb_gen: interrupt source stage in front of the Z80 interrupt controller.
// Produces three registered one-clock request strobes:
//   int_stbs[0] - programmable periodic timer (prescaler + down-counter)
//   int_stbs[1] - synchronised edge on ext_req[0], polarity selectable
//   int_stbs[2] - synchronised edge on ext_req[1], polarity selectable
// Optional feature: define INT_STB_GEN_ONESHOT_EN to store control bit din[3]
// as a one-shot flag that stops the timer after its next expiry.
module int_stb_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       din,
  input  logic             presc_wr,
  input  logic             reload_wr,
  input  logic             ctl_wr,
  input  logic [1:0]       ext_req,
  output logic [2:0]       int_stbs,
  output logic [CNT_W-1:0] cnt_rd
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // CPU-visible configuration
  logic [CNT_W-1:0] presc_r;
  logic [CNT_W-1:0] reload_r;
  logic             run_r;
  logic [1:0]       pol_r;
  logic             oneshot_s;

  // Timer state
  logic [CNT_W-1:0] psc_cnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] psc_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             tick_s;
  logic             expire_s;
  logic             run_nxt_s;

  // Edge-source synchronisers and detectors
  logic [1:0]       s1_r;
  logic [1:0]       s2_r;
  logic [1:0]       s3_r;
  logic [1:0]       edge_s;

  logic [2:0]       int_stbs_r;
  logic             din_unused_s;

`ifdef INT_STB_GEN_ONESHOT_EN
  logic oneshot_r;

  // One-shot flag: written with the control register, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oneshot_r <= 1'b0;
    end else if (ctl_wr) begin
      oneshot_r <= din[3];
    end else begin
      oneshot_r <= oneshot_r;
    end
  end

  assign oneshot_s    = oneshot_r;
  assign din_unused_s = ^din[7:4];
`else
  assign oneshot_s    = 1'b0;
  assign din_unused_s = ^din[7:3];
`endif

  // Timer next state; expiry is judged on the pre-write register values
  always_comb begin
    tick_s    = 1'b0;
    expire_s  = 1'b0;
    psc_nxt_s = CNT_ZERO;
    cnt_nxt_s = reload_r;
    if (run_r) begin
      tick_s = (psc_cnt_r == presc_r);
      if (tick_s) begin
        psc_nxt_s = CNT_ZERO;
        if (cnt_r == CNT_ZERO) begin
          expire_s  = 1'b1;
          cnt_nxt_s = reload_r;
        end else begin
          expire_s  = 1'b0;
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end else begin
        // A prescaler already past a freshly lowered presc runs on to the
        // natural 8-bit wrap before it can match again.
        psc_nxt_s = psc_cnt_r + CNT_ONE;
        cnt_nxt_s = cnt_r;
      end
    end else begin
      // Stopped: prescaler parked at zero, counter tracks the reload value
      tick_s    = 1'b0;
      expire_s  = 1'b0;
      psc_nxt_s = CNT_ZERO;
      cnt_nxt_s = reload_r;
    end
  end

  // Run flag next state: an explicit control write wins over one-shot stop
  always_comb begin
    run_nxt_s = run_r;
    if (ctl_wr) begin
      run_nxt_s = din[0];
    end else if (expire_s && oneshot_s) begin
      run_nxt_s = 1'b0;
    end else begin
      run_nxt_s = run_r;
    end
  end

  // Edge condition per source; s2 and s3 share pol so a polarity flip alone
  // never looks like an edge
  always_comb begin
    edge_s = (s2_r ^ pol_r) & ~(s3_r ^ pol_r);
  end

  // Configuration registers loaded from the shared CPU data bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r  <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      run_r    <= 1'b0;
      pol_r    <= 2'b00;
    end else begin
      if (presc_wr) begin
        presc_r <= din[CNT_W-1:0];
      end
      if (reload_wr) begin
        reload_r <= din[CNT_W-1:0];
      end
      if (ctl_wr) begin
        pol_r <= din[2:1];
      end
      run_r <= run_nxt_s;
    end
  end

  // Prescaler and down-counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_cnt_r <= CNT_ZERO;
      cnt_r     <= CNT_ZERO;
    end else begin
      psc_cnt_r <= psc_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  // Three-stage synchroniser; deliberately not reset so a line that is
  // steady across reset does not fake an edge afterwards
  always_ff @(posedge clk) begin
    s1_r <= ext_req;
    s2_r <= s1_r;
    s3_r <= s2_r;
  end

  // Registered request strobes, one clock wide each
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_stbs_r <= 3'b000;
    end else begin
      int_stbs_r <= {edge_s, expire_s};
    end
  end

  assign int_stbs = int_stbs_r;
  assign cnt_rd   = cnt_r;

endmodule

// File: tb/tb_int_stb_gen.sv
// tb_int_stb_gen: scoreboard bench for int_stb_gen.
// Stimulus pushes the cycle number at which each strobe must appear; a
// separate negedge monitor pops and compares whenever a strobe is seen.
module tb_int_stb_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       presc_wr = 1'b0;
  logic       reload_wr = 1'b0;
  logic       ctl_wr = 1'b0;
  logic [1:0] ext_req = 2'b00;
  logic [2:0] int_stbs;
  logic [7:0] cnt_rd;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  exp_q[3][$];
  bit  mon_en = 1'b0;
  logic [1:0] pol_m = 2'b00;
  logic [1:0] lvl_m = 2'b00;

  int_stb_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .presc_wr (presc_wr),
    .reload_wr(reload_wr),
    .ctl_wr   (ctl_wr),
    .ext_req  (ext_req),
    .int_stbs (int_stbs),
    .cnt_rd   (cnt_rd)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of its expectation queue
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        while (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL strobe%0d_missing: got no strobe by cycle %0d, required strobe at cycle %0d",
                   i, cyc, exp_q[i][0]);
          void'(exp_q[i].pop_front());
        end
        if (int_stbs[i] !== 1'b0) begin
          n_chk++;
          if (int_stbs[i] === 1'b1 && exp_q[i].size() > 0 && exp_q[i][0] == cyc) begin
            void'(exp_q[i].pop_front());
          end else begin
            n_fail++;
            $display("FAIL strobe%0d_unexpected: got %b at cycle %0d, required 0", i, int_stbs[i], cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind 0 = presc, 1 = reload, 2 = control; sampled at the next edge
  task automatic wr(input int kind, input logic [7:0] d);
    din       = d;
    presc_wr  = (kind == 0);
    reload_wr = (kind == 1);
    ctl_wr    = (kind == 2);
    step(1);
    presc_wr  = 1'b0;
    reload_wr = 1'b0;
    ctl_wr    = 1'b0;
  endtask

  function automatic logic [7:0] ctlv(input logic run, input logic os);
    return {4'b0000, os, pol_m, run};
  endfunction

  // Flip the selected lines; an edge matching the polarity strobes 3 edges later
  task automatic toggle(input logic [1:0] mask);
    for (int i = 0; i < 2; i++) begin
      if (mask[i]) begin
        lvl_m[i] = ~lvl_m[i];
        if ((lvl_m[i] ^ pol_m[i]) == 1'b1) exp_q[i+1].push_back(cyc + 3);
      end
    end
    ext_req = lvl_m;
  endtask

  // Periodic timer for n edges after the start write, then stop
  task automatic run_periodic(input int p, input int r, input int n);
    int w, per;
    wr(0, 8'(p));
    wr(1, 8'(r));
    step(2);
    chk("cnt_idle", int'(cnt_rd), r);
    per = (p + 1) * (r + 1);
    wr(2, ctlv(1'b1, 1'b0));
    w = cyc;
    for (int k = 1; k * per <= n; k++) exp_q[0].push_back(w + k * per);
    for (int m = 0; m < n - 1; m++) begin
      chk("cnt_run", int'(cnt_rd), r - ((m % per) / (p + 1)));
      step(1);
    end
    wr(2, ctlv(1'b0, 1'b0));
    step(1);
    chk("cnt_stop", int'(cnt_rd), r);
    step(2);
  endtask

  // Reload rewritten rofs edges after start; each period uses the reload
  // value held before the expiry edge that begins it
  task automatic run_reload_chg(input int p, input int r1, input int r2, input int rofs, input int n);
    int w, x, eff, rt;
    wr(0, 8'(p));
    wr(1, 8'(r1));
    step(2);
    wr(2, ctlv(1'b1, 1'b0));
    w  = cyc;
    rt = w + rofs;
    x  = w;
    eff = r1;
    while (1) begin
      x = x + (p + 1) * (eff + 1);
      if (x > w + n) break;
      exp_q[0].push_back(x);
      eff = (rt < x) ? r2 : r1;
    end
    if (rofs > 1) step(rofs - 1);
    wr(1, 8'(r2));
    step(n - rofs - 1);
    wr(2, ctlv(1'b0, 1'b0));
    step(1);
    chk("cnt_stop_rl", int'(cnt_rd), r2);
    step(2);
  endtask

  initial begin
    int p, r, per, n, w;
    step(4);
    mon_en = 1'b1;
    chk("rst_stbs", int'(int_stbs), 0);
    chk("rst_cnt", int'(cnt_rd), 0);
    rst_n = 1'b1;
    step(2);

    // Basic period 20, then reload change mid-period, then stop on expiry
    run_periodic(3, 4, 65);
    run_reload_chg(3, 4, 1, 5, 60);
    run_periodic(1, 2, 12);

    // Randomised timer settings, half stopping exactly on an expiry
    repeat (6) begin
      p = $urandom_range(0, 3);
      r = $urandom_range(0, 5);
      per = (p + 1) * (r + 1);
      if ($urandom_range(0, 1) == 1) n = per * $urandom_range(1, 3);
      else n = $urandom_range(2, 50);
      if (n < 2) n = 2;
      run_periodic(p, r, n);
    end
    repeat (3) begin
      p = $urandom_range(0, 2);
      r = $urandom_range(1, 4);
      per = (p + 1) * (r + 1);
      run_reload_chg(p, r, $urandom_range(0, 4), $urandom_range(1, 2 * per), 2 * per + 30);
    end

    // One-shot control write
    wr(0, 8'd0);
    wr(1, 8'd2);
    step(2);
    wr(2, ctlv(1'b1, 1'b1));
    w = cyc;
`ifdef INT_STB_GEN_ONESHOT_EN
    exp_q[0].push_back(w + 3);
`else
    for (int k = 1; 3 * k <= 15; k++) exp_q[0].push_back(w + 3 * k);
`endif
    step(14);
    wr(2, ctlv(1'b0, 1'b0));
    step(1);
    chk("cnt_oneshot", int'(cnt_rd), 2);
    step(3);

    // Source 1: rising edge, polarity flip with steady line, falling edge
    toggle(2'b01);
    step(5);
    pol_m = 2'b01;
    wr(2, ctlv(1'b0, 1'b0));
    step(3);
    toggle(2'b01);
    step(6);

    // Source 2 held high across a reset that lands mid timer period
    if (lvl_m[1] == 1'b0) toggle(2'b10);
    step(6);
    wr(0, 8'd3);
    wr(1, 8'd4);
    wr(2, ctlv(1'b1, 1'b0));
    step(6);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    pol_m = 2'b00;
    chk("cnt_after_rst", int'(cnt_rd), 0);
    step(25);
    toggle(2'b10);
    step(3);
    toggle(2'b10);
    step(6);

    // Cleared presc/reload: one strobe every clock
    wr(2, ctlv(1'b1, 1'b0));
    w = cyc;
    for (int k = 1; k <= 8; k++) exp_q[0].push_back(w + k);
    step(7);
    wr(2, ctlv(1'b0, 1'b0));
    step(1);
    chk("cnt_zero_cfg", int'(cnt_rd), 0);
    step(3);

    // Random edges on both lines with occasional polarity changes
    for (int it = 0; it < 40; it++) begin
      if (it % 8 == 7) begin
        step(4);
        pol_m = 2'($urandom_range(0, 3));
        wr(2, ctlv(1'b0, 1'b0));
      end
      toggle(2'($urandom_range(1, 3)));
      step($urandom_range(2, 4));
    end

    step(10);
    for (int i = 0; i < 3; i++) begin
      while (exp_q[i].size() > 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL strobe%0d_leftover: got none, required strobe at cycle %0d", i, exp_q[i][0]);
        void'(exp_q[i].pop_front());
      end
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/int_stb_gen.md
Name: int_stb_gen

Overview:
- Interrupt source stage directly upstream of the Z80 interrupt controller.
- Generates the three one-clock request strobes `int_stbs[2:0]` that the controller latches as pending requests:
  - source 0: programmable periodic timer.
  - sources 1, 2: synchronised edge detectors on asynchronous external request lines (e.g. MP3 decoder DREQ, DMA/SPI done).
- CPU configures the block via write strobes sharing the 8-bit data bus.

Parameters:
- `CNT_W`, 8, width of the timer prescaler and reload/counter registers (fixed 8 in this revision; `din` maps 1:1).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  8  CPU write data.
- `presc_wr`  in  1  write strobe, `presc <= din`.
- `reload_wr`  in  1  write strobe, `reload <= din`.
- `ctl_wr`  in  1  write strobe, control register: `din[0]` run, `din[1]` src1 polarity, `din[2]` src2 polarity, `din[3]` one-shot (optional feature only).
- `ext_req`  in  2  asynchronous external request lines; `ext_req[0]` drives source 1, `ext_req[1]` drives source 2.
- `int_stbs`  out  3  registered one-clock request strobes to the interrupt controller.
- `cnt_rd`  out  8  current timer counter value, for CPU readback.

Behaviour:

Reset (`rst_n` low at a rising edge):
- `presc`, `reload`, `run`, polarities, prescaler counter, timer counter, `int_stbs` all cleared to 0.
- Sync flops are NOT cleared: they keep shifting `ext_req` during reset, so a line held stable through reset produces no strobe.
- Reset mid-period: timer cleared, no strobe issued.

Timer:
- While `run` = 0: prescaler counter held at 0, counter held equal to `reload`, no source-0 strobes.
- While `run` = 1:
  - Prescaler counts 0..`presc`, then wraps to 0, producing a tick on the wrap cycle.
  - On a tick with counter ≠ 0, counter decrements.
  - On a tick with counter = 0 (expiry), counter reloads from `reload` and `int_stbs[0]` is high in the next cycle.
- Period is (`presc`+1)·(`reload`+1) clocks. `presc` = `reload` = 0 gives a strobe every clock.
- First strobe arrives (`presc`+1)·(`reload`+1) clocks after the `ctl_wr` edge that sets `run`.

Simultaneous events (expiry evaluated on pre-write state):
- `reload_wr` on an expiry cycle: the counter loads the old `reload`; the new value takes effect from the next expiry.
- `ctl_wr` clearing `run` on an expiry cycle: the strobe is still emitted, then the timer stops.
- `presc_wr` while running: the new value is compared from the next cycle. If the prescaler counter already exceeds the new `presc`, it counts up to 255, wraps, and only then ticks.
- Arithmetic is unsigned and modulo 2^8; no other wrap cases.

Edge sources i = 1, 2:
- 3-flop shift `s1`→`s2`→`s3` of `ext_req[i-1]`.
- Edge condition: `(s2^pol) & ~(s3^pol)`, i.e. rising edge for pol = 0, falling edge for pol = 1.
- The edge condition is registered into `int_stbs[i]` for exactly one cycle.
- Latency: if the new level is first captured by `s1` at edge E0, `int_stbs[i]` is high from E2 to E3.
- Changing polarity never creates a strobe by itself, because `s2` and `s3` use the same `pol`.
- Pulses narrower than one clock may be missed. Consecutive edges at least 2 clocks apart each give a separate strobe.

Output rules:
- `int_stbs` is always registered, never combinational.
- Multiple bits may be high in the same cycle; priority is resolved downstream.
- `cnt_rd` equals the counter register, with no added latency.

Optional Feature:
- Macro: `INT_STB_GEN_ONESHOT_EN`.
- Defined: control bit `din[3]` is stored as `oneshot`.
  - With `oneshot` = 1, an expiry emits the strobe, reloads the counter, and clears `run` in the same edge; the timer then stays idle until `run` is rewritten.
  - `oneshot` resets to 0.
- Undefined: `din[3]` is ignored and the timer is always periodic.

Test Plan:
1. Reset, `presc`=3, `reload`=4, `ctl`=0x01 → `int_stbs[0]` pulses for 1 cycle every 20 clocks, first pulse 20 clocks after `ctl_wr`; no other bits set.
2. Running timer, `reload_wr`=1 mid-period → current period completes at the old length (20), subsequent periods are 8 clocks.
3. `ext_req[0]` rises at E0, `pol`=0 → `int_stbs[1]` high E2..E3 only; then `ctl`=0x03 (pol1=1) with line steady → no strobe; falling edge → one strobe.
4. `ext_req[1]` high throughout and across a `rst_n` pulse → no `int_stbs[2]` after reset; 1-0-1 toggle with 3-clock spacing → exactly one rising-edge strobe.
5. `ctl_wr` clearing `run` on the exact expiry cycle → final strobe still issued, no further strobes, `cnt_rd` = `reload`.
6. With `INT_STB_GEN_ONESHOT_EN`, `ctl`=0x09, `presc`=0, `reload`=2 → single strobe after 3 clocks, `run` reads 0 afterwards; without the macro, the same write gives a strobe every 3 clocks.
